// File: rtl/vec_issue_seq.sv
// Decode-and-issue stage: expands one 16-bit instruction into per-element micro-op beats.
// Latency: first beat is registered, 1 cycle after instruction accept; one beat per accepted cycle.
// Backpressure: beats hold stable while uop_ready=0; instr_ready only when idle or the last beat is leaving.
//
// Ports:
//   clk, rst_n (async active-low), flush (sync abort, highest priority)
//   instr_valid/instr/instr_ready : fetch side handshake, opcode in instr[15:12]
//   uop_valid/uop_ready           : micro-op beat handshake
//   functype, v_en, s_en, addr1, addr2, dst_addr, elem_idx, offset, immediate, uop_last : beat payload
//   busy (state != IDLE), illegal (one-cycle pulse after accepting an unknown opcode)
module vec_issue_seq #(
    parameter int  VLEN      = 16,
    parameter int  VLD_DRAIN = 1,
    localparam int IDX_W     = $clog2(VLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [3:0]       functype,
    output logic             v_en,
    output logic             s_en,
    output logic [2:0]       addr1,
    output logic [2:0]       addr2,
    output logic [2:0]       dst_addr,
    output logic [IDX_W-1:0] elem_idx,
    output logic [5:0]       offset,
    output logic [7:0]       immediate,
    output logic             uop_last,
    output logic             busy,
    output logic             illegal
);

    localparam logic [3:0] OP_VADD = 4'h0;
    localparam logic [3:0] OP_VDOT = 4'h1;
    localparam logic [3:0] OP_SMUL = 4'h2;
    localparam logic [3:0] OP_SST  = 4'h3;
    localparam logic [3:0] OP_VLD  = 4'h4;
    localparam logic [3:0] OP_VST  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SLH  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);
    // Index of the final drain beat; unused when VLD_DRAIN is 0.
    localparam logic [1:0] DRAIN_LAST = 2'(VLD_DRAIN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic             vld;
        logic [3:0]       functype;
        logic             v_en;
        logic             s_en;
        logic [2:0]       addr1;
        logic [2:0]       addr2;
        logic [2:0]       dst;
        logic [IDX_W-1:0] idx;
        logic [5:0]       offset;
        logic [7:0]       imm;
        logic             last;
    } uop_t;

    state_t     state_q, state_d;
    uop_t       uop_q, uop_d;
    logic [1:0] drain_q, drain_d;
    logic       illegal_q, illegal_d;

    logic             accept;
    logic             fire;
    logic [IDX_W-1:0] idx_inc;
    logic             idx_inc_last;

    // Beat 0 of a freshly accepted instruction; vld=0 for NOP and unknown opcodes.
    function automatic uop_t decode(input logic [15:0] ins);
        uop_t u;
        u          = '0;
        u.functype = ins[15:12];
        unique case (ins[15:12])
            OP_VADD: begin
                u.vld = 1'b1; u.v_en = 1'b1;
                u.addr1 = ins[8:6]; u.addr2 = ins[5:3]; u.dst = ins[11:9];
            end
            OP_VDOT: begin
                // s_en only appears on the final element (VLEN >= 2 so never beat 0)
                u.vld = 1'b1;
                u.addr1 = ins[8:6]; u.addr2 = ins[5:3]; u.dst = ins[11:9];
            end
            OP_SMUL: begin
                u.vld = 1'b1; u.s_en = 1'b1; u.last = 1'b1;
                u.addr1 = ins[8:6]; u.addr2 = ins[5:3]; u.dst = ins[11:9];
            end
            OP_SST: begin
                u.vld = 1'b1; u.last = 1'b1;
                u.addr1 = ins[8:6]; u.addr2 = ins[11:9]; u.offset = ins[5:0];
            end
            OP_VLD: begin
                u.vld = 1'b1; u.v_en = 1'b1;
                u.addr1 = ins[8:6]; u.dst = ins[11:9]; u.offset = ins[5:0];
            end
            OP_VST: begin
                u.vld = 1'b1;
                u.addr1 = ins[8:6]; u.addr2 = ins[11:9]; u.offset = ins[5:0];
            end
            OP_SLL, OP_SLH: begin
                u.vld = 1'b1; u.s_en = 1'b1; u.last = 1'b1;
                u.addr1 = ins[11:9]; u.dst = ins[11:9]; u.imm = ins[7:0];
            end
            OP_J: begin
                u.vld = 1'b1; u.last = 1'b1;
                u.imm = ins[7:0];
            end
            default: u = '0;
        endcase
        return u;
    endfunction

    assign fire        = uop_q.vld & uop_ready;
    assign instr_ready = ~flush & ((state_q == S_IDLE) | (fire & uop_q.last));
    assign accept      = instr_valid & instr_ready;

    assign idx_inc      = uop_q.idx + IDX_W'(1);
    assign idx_inc_last = (idx_inc == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        uop_d     = uop_q;
        drain_d   = drain_q;
        illegal_d = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            uop_d   = '0;
            drain_d = '0;
        end else if (accept) begin
            // Covers both the idle case and back-to-back issue on the last beat.
            uop_d     = decode(instr);
            drain_d   = '0;
            illegal_d = (instr[15:12] >= 4'h9) && (instr[15:12] <= 4'hE);
            state_d   = uop_d.vld ? S_ISSUE : S_IDLE;
        end else if (fire) begin
            if (uop_q.last) begin
                state_d = S_IDLE;
                uop_d   = '0;
            end else if (state_q == S_DRAIN) begin
                drain_d    = drain_q + 2'd1;
                uop_d.last = ((drain_q + 2'd1) == DRAIN_LAST);
            end else if (uop_q.idx == LAST_IDX) begin
                // Only a VLD with drain beats reaches here: element index stays at VLEN-1.
                state_d    = S_DRAIN;
                uop_d.v_en = 1'b0;
                drain_d    = '0;
                uop_d.last = (DRAIN_LAST == 2'd0);
            end else begin
                uop_d.idx  = idx_inc;
                uop_d.last = idx_inc_last && !((uop_q.functype == OP_VLD) && (VLD_DRAIN > 0));
                if (uop_q.functype == OP_VDOT) begin
                    uop_d.s_en = idx_inc_last;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            uop_q     <= '0;
            drain_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            uop_q     <= uop_d;
            drain_q   <= drain_d;
            illegal_q <= illegal_d;
        end
    end

    assign uop_valid = uop_q.vld;
    assign functype  = uop_q.functype;
    assign v_en      = uop_q.v_en;
    assign s_en      = uop_q.s_en;
    assign addr1     = uop_q.addr1;
    assign addr2     = uop_q.addr2;
    assign dst_addr  = uop_q.dst;
    assign elem_idx  = uop_q.idx;
    assign offset    = uop_q.offset;
    assign immediate = uop_q.imm;
    assign uop_last  = uop_q.last;
    assign busy      = (state_q != S_IDLE);
    assign illegal   = illegal_q;

endmodule

// File: doc/vec_issue_seq.md
Name: vec_issue_seq

Overview:
- Sequential decode-and-issue stage for the vector/scalar ISA; successor to the combinational instruction decoder.
- Accepts one 16-bit instruction per valid/ready handshake and expands it into per-element micro-ops. Vector ops produce one beat per element index; scalar ops produce one beat.
- Sits between the fetch stage and the register files / LSU. Replaces the fixed cycleCount field with a parametrised element sequencer that supports back-pressure and flush.

Parameters:
- VLEN, 16, elements per vector register; legal range 2..256.
- IDX_W, $clog2(VLEN), element index width; localparam, derived, not overridable.
- VLD_DRAIN, 1, extra non-writing beats appended after a VLD to cover load latency; legal range 0..3.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the current instruction.
- instr_valid  input  1  fetch presents instr.
- instr  input  16  instruction word; [15:12] opcode.
- instr_ready  output  1  stage can accept instr this cycle.
- uop_valid  output  1  micro-op beat valid.
- uop_ready  input  1  downstream accepts beat.
- functype  output  4  opcode of the current instruction.
- v_en  output  1  vector register write enable for this beat.
- s_en  output  1  scalar register write enable for this beat.
- addr1  output  3  source 1 register.
- addr2  output  3  source 2 register.
- dst_addr  output  3  destination register.
- elem_idx  output  IDX_W  element index of this beat.
- offset  output  6  memory offset.
- immediate  output  8  immediate.
- uop_last  output  1  final beat of the instruction.
- busy  output  1  state != IDLE.
- illegal  output  1  one-cycle pulse when an unknown opcode is accepted.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; every registered output = 0; instr_ready=1.
- Opcodes and beats:
  - VADD=0: VLEN beats. v_en=1. addr1=[8:6], addr2=[5:3], dst=[11:9].
  - VDOT=1: VLEN beats. Same field mapping as VADD. v_en=0; s_en=1 only on the last beat.
  - SMUL=2: 1 beat. s_en=1. Fields as VADD.
  - SST=3: 1 beat. addr1=[8:6], addr2=[11:9], offset=[5:0]; no enables.
  - VLD=4: VLEN beats with v_en=1, addr1=[8:6], dst=[11:9], offset=[5:0]; then VLD_DRAIN beats with v_en=0 and elem_idx held at VLEN-1.
  - VST=5: VLEN beats. addr1=[8:6], addr2=[11:9], offset=[5:0]; no enables.
  - SLL=6, SLH=7: 1 beat. s_en=1. addr1=dst=[11:9], imm=[7:0].
  - J=8: 1 beat. imm=[7:0].
  - NOP=F: accepted and consumed; no beat emitted.
  - 9..E: treated as NOP; illegal pulses on the cycle after acceptance.
  - Unused fields are 0.
- FSM:
  - IDLE -> ISSUE on accept of any beat-producing opcode.
  - ISSUE -> DRAIN when the VLEN-1 beat is accepted, VLD only, and only if VLD_DRAIN>0.
  - ISSUE or DRAIN -> IDLE when the uop_last beat is accepted and no new instruction is accepted in the same cycle.
  - ISSUE or DRAIN -> ISSUE when the last beat is accepted and a new instruction is accepted in the same cycle (back-to-back).
- Handshake:
  - instr_ready = (state==IDLE) | (uop_valid & uop_ready & uop_last). This is combinational from uop_ready.
  - Accept = instr_valid & instr_ready. The first beat is registered and appears the next cycle, so latency is 1 cycle.
  - A beat advances only on uop_valid & uop_ready. While uop_ready=0, every uop output is held stable.
  - elem_idx starts at 0 and increments by 1 per accepted beat; it never wraps inside an instruction.
  - uop_last is asserted on the final beat only: beat VLEN-1, or the last drain beat for VLD, or the single beat of scalar ops.
- flush: has priority over everything. Next cycle: state=IDLE, uop_valid=0, enables=0. The instruction offered in the flush cycle is not accepted (instr_ready forced 0 during flush).
- Reset asserted mid-instruction: immediate return to the reset values; the partially issued instruction is abandoned.

Test Plan:
- VLEN=16; VADD 0x0A98 (dst=5, a1=2, a2=3), uop_ready=1 -> 16 beats on consecutive cycles, elem_idx 0..15, v_en=1, uop_last on beat 15, busy low after.
- VLD 0x4A45 with VLD_DRAIN=1 -> 16 beats v_en=1 with offset=5, then 1 beat v_en=0, elem_idx=15, uop_last=1; total 17 beats.
- VADD with uop_ready toggling 1,0,0,1,... -> fields and elem_idx held while stalled; all 16 indices emitted exactly once, in order.
- Back-to-back: VST then SLL 0x6A7F offered continuously -> SLL accepted in the cycle of VST beat 15; SLL beat (s_en=1, dst=5, imm=0x7F) on the next cycle with no bubble.
- Opcode 0xB000 accepted -> illegal=1 for one cycle, no uop_valid; NOP 0xF000 -> no beat, no illegal.
- flush at VADD beat 7 -> uop_valid=0 the next cycle, state IDLE. rst_n low during VDOT beat 3 -> all outputs 0 immediately; s_en never pulses.
